snitch_shared_muldiv_arbiter: RTL and testbench
===============================================

# snitch_shared_muldiv_arbiter

Shares one cluster-level multiply/divide unit (accelerator address `SHARED_MULDIV` in `snitch_pkg::acc_addr_e`) among the cluster's Snitch cores. It arbitrates offloaded requests round-robin, registers the winner towards the unit, and tags each request with the core index. Responses are routed back by that tag, and total in-flight operations are bounded. It sits between the per-core accelerator offload ports and the single shared MDU.

## Interface
- `NrCores`, 4: number of requesting cores, 1..16.
- `DataWidth`, 32: operand/result width.
- `IdWidth`, 5: core-side destination-register id width.
- `MaxOutstanding`, 4: maximum requests accepted but not yet answered, ≥1.
- `CoreIdxW`, `$clog2(NrCores)` (min 1): derived tag width; MDU-side id width = `IdWidth+CoreIdxW`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `core_qvalid_i` in NrCores: per-core request valid.
- `core_qready_o` out NrCores: per-core request ready; one-hot or zero.
- `core_qid_i` in NrCores×IdWidth: rd id.
- `core_qdata_op_i` in NrCores×32: instruction word.
- `core_qdata_arga_i`, `core_qdata_argb_i` in NrCores×DataWidth: operands.
- `core_pvalid_o` out NrCores: per-core response valid; one-hot or zero.
- `core_pready_i` in NrCores: per-core response ready.
- `core_pid_o` out IdWidth: response rd id, shared by all cores.
- `core_pdata_o` out DataWidth: response data, shared by all cores.
- `core_perror_o` out 1: response error, shared by all cores.
- `mdu_qvalid_o` out 1, `mdu_qready_i` in 1: request handshake to the MDU.
- `mdu_qid_o` out IdWidth+CoreIdxW: `{core_idx, rd}`.
- `mdu_qdata_op_o` out 32, `mdu_qdata_arga_o`/`mdu_qdata_argb_o` out DataWidth: request payload.
- `mdu_pvalid_i` in 1, `mdu_pready_o` out 1, `mdu_pid_i` in IdWidth+CoreIdxW, `mdu_pdata_i` in DataWidth, `mdu_perror_i` in 1: response channel.
- `stat_grants_o` out NrCores×32: per-core grant counters.
- `stat_full_cycles_o` out 32: cycles with a valid request blocked by the outstanding limit.

## Operation
- **Request register.** A single register `req_q` holds payload plus `valid_q`. `mdu_qvalid_o = valid_q`; payload comes directly from the register.
- **Accept condition.** `accept = (!valid_q || mdu_qready_i) && (inflight_q < MaxOutstanding) && |core_qvalid_i`.
- **Arbitration.**
  - Pointer `rr_q`. The winner is the lowest index ≥ `rr_q` with valid, wrapping to 0.
  - `core_qready_o[winner] = accept`.
  - On accept, `rr_q <= (winner+1) mod NrCores`. Otherwise `rr_q` is held.
- **Tagging.** The loaded register gets `mdu_qid_o = {winner, core_qid_i[winner]}`.
- **Outstanding counter.**
  - `inflight_q` has width `$clog2(MaxOutstanding+1)`.
  - +1 on a core request handshake; −1 on a core response handshake; both in the same cycle gives no change.
  - Never exceeds `MaxOutstanding`, never underflows. A response with `inflight_q==0` is a protocol error; flag it by assertion.
- **Response routing (combinational).**
  - `idx = mdu_pid_i[top CoreIdxW bits]`.
  - `core_pvalid_o[idx] = mdu_pvalid_i`.
  - `mdu_pready_o = core_pready_i[idx]`.
  - `core_pid_o`, `core_pdata_o`, `core_perror_o` pass through.
- **Illegal index.** If `idx ≥ NrCores`, the response is dropped: `mdu_pready_o=1`, no `core_pvalid_o`, `inflight_q` decrements, and an assertion fires.
- **Stability.** Once `valid_q` is set, the payload is stable until `mdu_qready_i`. A blocked core's `core_qready_o` stays low; the core holds its request.

## Timing
- **Reset values.** All outputs reset to 0: `valid_q=0`, `rr_q=0`, `inflight_q=0`, stat counters 0.
- **Request latency.** A core handshake in cycle t gives `mdu_qvalid_o` in t+1.
- **Throughput.** Back-to-back one-per-cycle when `mdu_qready_i` stays high and the outstanding limit is not hit.
- **Response latency.** 0 cycles (combinational), MDU to core.
- **Full boundary.**
  - At `inflight_q==MaxOutstanding`, all `core_qready_o` are 0.
  - A response handshake in that cycle does not free a slot until t+1: the counter gates on the registered value.
- **Async reset mid-operation.** Drops `req_q` and the counters immediately. MDU state is reset by the same `rst_ni`.

## Configuration
- **`SNITCH_MULDIV_ARB_STATS_EN` defined:**
  - `stat_grants_o[i]` increments on each core-i request handshake, wrapping at 2^32.
  - `stat_full_cycles_o` increments each cycle where `|core_qvalid_i && inflight_q==MaxOutstanding`.
- **Undefined:** no counter flops; both stat outputs are tied to 0. Ports are unchanged.

## Structure
- Add `snitch_pkg::muldiv_arb_stats_t` (grant array + full-cycle counter) for the stats outputs.
- The tag layout `{core_idx, rd}` is also documented in `snitch_pkg` as a localparam helper.
- Sub-module `snitch_muldiv_rr_pick`: combinational round-robin picker (inputs: valid vector, `rr_q`; outputs: winner index, any-valid).
- The pointer register, request register, counter and stats live in the top module.

## Test plan
- **Single core:** core 2 sends op with arga=6, argb=7, rd=3, MDU always ready → `mdu_qid_o={2,3}` one cycle later; response pid `{2,3}` data 42 → only `core_pvalid_o[2]`, `core_pid_o=3`, `core_pdata_o=42`.
- **Fairness:** all 4 cores valid continuously, MDU ready, responses immediate → grant order 0,1,2,3,0; each `stat_grants_o` = 25 after 100 grants (macro on).
- **Outstanding limit:** `MaxOutstanding=4`, MDU accepts but withholds responses → exactly 4 grants, then `core_qready_o=0` and `stat_full_cycles_o` counts. Releasing one response allows exactly one grant the cycle after.
- **Backpressure:** `mdu_qready_i=0` for 5 cycles with core 1 loaded → `mdu_qid_o`/payload stable for all 5 cycles, no other core readied. Ready high → next winner loads the same cycle.
- **Response stall:** response to core 3 with `core_pready_i[3]=0` for 3 cycles → `mdu_pready_o=0`, `inflight_q` unchanged until the handshake.
- **Reset mid-flight:** assert `rst_ni` with `valid_q=1` and `inflight_q=3` → all outputs 0 immediately. After release, the first grant goes to core 0.

Source files
------------

// File: rtl/snitch_pkg.sv
// Cluster-shared Snitch types: accelerator addresses, shared MULDIV arbiter statistics and tag layout.
// Pure declarations, no logic; no latency or backpressure of its own.
package snitch_pkg;

   typedef enum logic [31:0] {
      FP_SS         = 32'd0,
      SHARED_MULDIV = 32'd1,
      DMA_SS        = 32'd2
   } acc_addr_e;

   localparam int unsigned MuldivArbMaxCores = 16;

   // Only the low NrCores grant entries are meaningful; the rest stay zero.
   typedef struct packed {
      logic [MuldivArbMaxCores-1:0][31:0] grants;
      logic [31:0]                        full_cycles;
   } muldiv_arb_stats_t;

   // MDU-side tag is {core_idx, rd}: rd sits at bit 0, core_idx directly above it.
   localparam int unsigned MuldivTagRdLsb = 0;

   function automatic int unsigned muldiv_tag_idx_lsb(input int unsigned id_width);
      return id_width;
   endfunction

endpackage

// File: rtl/snitch_muldiv_rr_pick.sv
// Round-robin picker: lowest valid index at or above rr, wrapping to 0.
// Purely combinational, no backpressure; the caller decides when the pointer moves.
module snitch_muldiv_rr_pick #(
   parameter int unsigned NrCores = 4,
   parameter int unsigned IdxW    = 2
) (
   input  logic [NrCores-1:0] valid,
   input  logic [IdxW-1:0]    rr,
   output logic [IdxW-1:0]    winner,
   output logic               any
);

   logic [IdxW-1:0] cand;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      cand   = '0;
      for (int unsigned i = 0; i < NrCores; i++) begin
         cand = IdxW'((32'(rr) + i) % NrCores);
         if (!any && valid[cand]) begin
            any    = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/snitch_shared_muldiv_arbiter.sv
// Shares one MDU among NrCores cores: round-robin, registered request (1 cycle), combinational response routing.
// Stalls cores while the request register is held or MaxOutstanding is reached; stats only with SNITCH_MULDIV_ARB_STATS_EN.
module snitch_shared_muldiv_arbiter
   import snitch_pkg::*;
#(
   parameter int unsigned NrCores        = 4,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned IdWidth        = 5,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned CoreIdxW       = (NrCores > 1) ? $clog2(NrCores) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NrCores-1:0]                  core_qvalid_i,
   output logic [NrCores-1:0]                  core_qready_o,
   input  logic [NrCores-1:0][IdWidth-1:0]     core_qid_i,
   input  logic [NrCores-1:0][31:0]            core_qdata_op_i,
   input  logic [NrCores-1:0][DataWidth-1:0]   core_qdata_arga_i,
   input  logic [NrCores-1:0][DataWidth-1:0]   core_qdata_argb_i,
   output logic [NrCores-1:0]                  core_pvalid_o,
   input  logic [NrCores-1:0]                  core_pready_i,
   output logic [IdWidth-1:0]                  core_pid_o,
   output logic [DataWidth-1:0]                core_pdata_o,
   output logic                                core_perror_o,
   output logic                                mdu_qvalid_o,
   input  logic                                mdu_qready_i,
   output logic [IdWidth+CoreIdxW-1:0]         mdu_qid_o,
   output logic [31:0]                         mdu_qdata_op_o,
   output logic [DataWidth-1:0]                mdu_qdata_arga_o,
   output logic [DataWidth-1:0]                mdu_qdata_argb_o,
   input  logic                                mdu_pvalid_i,
   output logic                                mdu_pready_o,
   input  logic [IdWidth+CoreIdxW-1:0]         mdu_pid_i,
   input  logic [DataWidth-1:0]                mdu_pdata_i,
   input  logic                                mdu_perror_i,
   output logic [NrCores-1:0][31:0]            stat_grants_o,
   output logic [31:0]                         stat_full_cycles_o
);

   localparam int unsigned InflW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned TagW   = IdWidth + CoreIdxW;
   localparam int unsigned IdxLsb = muldiv_tag_idx_lsb(IdWidth);

   logic                 valid_q;
   logic [TagW-1:0]      qid_q;
   logic [31:0]          op_q;
   logic [DataWidth-1:0] arga_q, argb_q;
   logic [CoreIdxW-1:0]  rr_q, winner, idx;
   logic [InflW-1:0]     inflight_q;
   logic                 any_vld, accept, not_full, full, idx_ok, resp_hs;

   snitch_muldiv_rr_pick #(
      .NrCores (NrCores),
      .IdxW    (CoreIdxW)
   ) i_rr_pick (
      .valid  (core_qvalid_i),
      .rr     (rr_q),
      .winner (winner),
      .any    (any_vld)
   );

   // Gate on the registered count so a same-cycle response never frees a slot early.
   assign full     = (inflight_q == InflW'(MaxOutstanding));
   assign not_full = (inflight_q <  InflW'(MaxOutstanding));
   assign accept   = (!valid_q || mdu_qready_i) && not_full && any_vld;

   always_comb begin
      core_qready_o = '0;
      if (accept) core_qready_o[winner] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         qid_q   <= '0;
         op_q    <= '0;
         arga_q  <= '0;
         argb_q  <= '0;
         rr_q    <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         qid_q   <= {winner, core_qid_i[winner]};
         op_q    <= core_qdata_op_i[winner];
         arga_q  <= core_qdata_arga_i[winner];
         argb_q  <= core_qdata_argb_i[winner];
         rr_q    <= (winner == CoreIdxW'(NrCores - 1)) ? '0 : winner + CoreIdxW'(1);
      end else if (mdu_qready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign mdu_qvalid_o     = valid_q;
   assign mdu_qid_o        = qid_q;
   assign mdu_qdata_op_o   = op_q;
   assign mdu_qdata_arga_o = arga_q;
   assign mdu_qdata_argb_o = argb_q;

   // Responses tagged with a nonexistent core are swallowed so the MDU never deadlocks.
   assign idx    = mdu_pid_i[IdxLsb +: CoreIdxW];
   assign idx_ok = (32'(idx) < NrCores);

   always_comb begin
      core_pvalid_o = '0;
      mdu_pready_o  = 1'b1;
      if (idx_ok) begin
         core_pvalid_o[idx] = mdu_pvalid_i;
         mdu_pready_o       = core_pready_i[idx];
      end
   end

   assign resp_hs       = mdu_pvalid_i && mdu_pready_o;
   assign core_pid_o    = mdu_pid_i[MuldivTagRdLsb +: IdWidth];
   assign core_pdata_o  = mdu_pdata_i;
   assign core_perror_o = mdu_perror_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q <= '0;
      end else if (accept && !resp_hs) begin
         inflight_q <= inflight_q + InflW'(1);
      end else if (!accept && resp_hs && (inflight_q != '0)) begin
         inflight_q <= inflight_q - InflW'(1);
      end
   end

   muldiv_arb_stats_t stats;
   logic              stats_unused;

`ifdef SNITCH_MULDIV_ARB_STATS_EN
   logic [NrCores-1:0][31:0] grant_q;
   logic [31:0]              full_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q <= '0;
         full_q  <= '0;
      end else begin
         for (int i = 0; i < NrCores; i++) begin
            if (accept && (32'(winner) == i)) grant_q[i] <= grant_q[i] + 32'd1;
         end
         if (|core_qvalid_i && full) full_q <= full_q + 32'd1;
      end
   end

   always_comb begin
      stats                       = '0;
      stats.grants[NrCores-1:0]   = grant_q;
      stats.full_cycles           = full_q;
   end
`else
   assign stats = '0;
`endif

   assign stat_grants_o      = stats.grants[NrCores-1:0];
   assign stat_full_cycles_o = stats.full_cycles;
   assign stats_unused       = ^{stats, full};

   assert property (@(posedge clk_i) disable iff (!rst_ni) resp_hs |-> (inflight_q != '0));
   assert property (@(posedge clk_i) disable iff (!rst_ni) mdu_pvalid_i |-> idx_ok);

endmodule

// File: tb/tb_snitch_shared_muldiv_arbiter.sv
// Directed bench for the shared MULDIV arbiter: reset, routing, fairness, limit, backpressure, stall, mid-flight reset.
// Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
module tb_snitch_shared_muldiv_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        core_qvalid, core_qready, core_pvalid, core_pready;
   logic [3:0][4:0]   core_qid;
   logic [3:0][31:0]  core_op, core_a, core_b, stat_grants;
   logic [4:0]        core_pid;
   logic [31:0]       core_pdata, mdu_op, mdu_a, mdu_b, mdu_pdata, stat_full;
   logic              core_perror, mdu_qvalid, mdu_qready, mdu_pvalid, mdu_pready, mdu_perror;
   logic [6:0]        mdu_qid, mdu_pid;

   int n_pass  = 0;
   int n_total = 0;

`ifdef SNITCH_MULDIV_ARB_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   always #5 clk = ~clk;

   snitch_shared_muldiv_arbiter dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .core_qvalid_i      (core_qvalid),
      .core_qready_o      (core_qready),
      .core_qid_i         (core_qid),
      .core_qdata_op_i    (core_op),
      .core_qdata_arga_i  (core_a),
      .core_qdata_argb_i  (core_b),
      .core_pvalid_o      (core_pvalid),
      .core_pready_i      (core_pready),
      .core_pid_o         (core_pid),
      .core_pdata_o       (core_pdata),
      .core_perror_o      (core_perror),
      .mdu_qvalid_o       (mdu_qvalid),
      .mdu_qready_i       (mdu_qready),
      .mdu_qid_o          (mdu_qid),
      .mdu_qdata_op_o     (mdu_op),
      .mdu_qdata_arga_o   (mdu_a),
      .mdu_qdata_argb_o   (mdu_b),
      .mdu_pvalid_i       (mdu_pvalid),
      .mdu_pready_o       (mdu_pready),
      .mdu_pid_i          (mdu_pid),
      .mdu_pdata_i        (mdu_pdata),
      .mdu_perror_i       (mdu_perror),
      .stat_grants_o      (stat_grants),
      .stat_full_cycles_o (stat_full)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      core_qvalid = '0;
      core_pready = '1;
      core_qid    = '0;
      core_op     = '0;
      core_a      = '0;
      core_b      = '0;
      mdu_qready  = 1'b1;
      mdu_pvalid  = 1'b0;
      mdu_pid     = '0;
      mdu_pdata   = '0;
      mdu_perror  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #3;
      n_total++;
      if (mdu_qvalid !== 1'b0) $display("FAIL reset_qvalid got=%0h exp=0", mdu_qvalid); else n_pass++;
      n_total++;
      if ({mdu_qid, mdu_op, mdu_a, mdu_b} !== '0) $display("FAIL reset_payload got=%0h exp=0", {mdu_qid, mdu_op, mdu_a, mdu_b}); else n_pass++;
      n_total++;
      if ({core_qready, core_pvalid} !== 8'h00) $display("FAIL reset_core_hs got=%0h exp=0", {core_qready, core_pvalid}); else n_pass++;
      n_total++;
      if (stat_grants !== '0) $display("FAIL reset_grants got=%0h exp=0", stat_grants); else n_pass++;
      n_total++;
      if (stat_full !== 32'd0) $display("FAIL reset_full got=%0h exp=0", stat_full); else n_pass++;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single();
      do_reset();
      core_qvalid = 4'b0100;
      core_qid[2] = 5'd3;
      core_op[2]  = 32'h0262_8533;
      core_a[2]   = 32'd6;
      core_b[2]   = 32'd7;
      #1;
      n_total++;
      if (core_qready !== 4'b0100) $display("FAIL single_qready got=%0h exp=4", core_qready); else n_pass++;
      tick();
      core_qvalid = '0;
      #1;
      n_total++;
      if ({mdu_qvalid, mdu_qid} !== {1'b1, 2'd2, 5'd3}) $display("FAIL single_tag got=%0h exp=%0h", {mdu_qvalid, mdu_qid}, {1'b1, 2'd2, 5'd3}); else n_pass++;
      n_total++;
      if ({mdu_op, mdu_a, mdu_b} !== {32'h0262_8533, 32'd6, 32'd7}) $display("FAIL single_payload got=%0h", {mdu_op, mdu_a, mdu_b}); else n_pass++;
      mdu_pvalid = 1'b1;
      mdu_pid    = {2'd2, 5'd3};
      mdu_pdata  = 32'd42;
      #1;
      n_total++;
      if ({core_pvalid, mdu_pready} !== {4'b0100, 1'b1}) $display("FAIL single_route got=%0h exp=9", {core_pvalid, mdu_pready}); else n_pass++;
      n_total++;
      if ({core_pid, core_pdata, core_perror} !== {5'd3, 32'd42, 1'b0}) $display("FAIL single_resp got=%0h", {core_pid, core_pdata, core_perror}); else n_pass++;
      tick();
      mdu_pvalid = 1'b0;
      #1;
      n_total++;
      if (dut.inflight_q !== 3'd0) $display("FAIL single_inflight got=%0d exp=0", dut.inflight_q); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rdy;
      do_reset();
      core_qvalid = 4'b1111;
      for (int k = 0; k < 100; k++) begin
         if (k > 0) begin
            mdu_pvalid = 1'b1;
            mdu_pid    = {2'((k - 1) % 4), 5'd0};
         end
         #1;
         if (k < 5) begin
            exp_rdy = 4'(1 << (k % 4));
            n_total++;
            if (core_qready !== exp_rdy) $display("FAIL fair_grant%0d got=%0h exp=%0h", k, core_qready, exp_rdy); else n_pass++;
         end
         tick();
      end
      core_qvalid = '0;
      mdu_pvalid  = 1'b1;
      mdu_pid     = {2'd3, 5'd0};
      tick();
      mdu_pvalid = 1'b0;
      #1;
      n_total++;
      if (stat_grants !== (StatsOn ? {4{32'd25}} : 128'd0)) $display("FAIL fair_stats got=%0h", stat_grants); else n_pass++;
      n_total++;
      if (dut.inflight_q !== 3'd0) $display("FAIL fair_inflight got=%0d exp=0", dut.inflight_q); else n_pass++;
   endtask

   task automatic test_outstanding();
      logic [3:0] exp_rdy;
      do_reset();
      core_qvalid = 4'b1111;
      for (int k = 0; k < 7; k++) begin
         #1;
         exp_rdy = (k < 4) ? 4'(1 << k) : 4'b0000;
         n_total++;
         if (core_qready !== exp_rdy) $display("FAIL limit_cycle%0d got=%0h exp=%0h", k, core_qready, exp_rdy); else n_pass++;
         tick();
      end
      #1;
      n_total++;
      if (stat_full !== (StatsOn ? 32'd3 : 32'd0)) $display("FAIL limit_full_cycles got=%0d exp=%0d", stat_full, StatsOn ? 3 : 0); else n_pass++;
      mdu_pvalid = 1'b1;
      mdu_pid    = {2'd0, 5'd0};
      #1;
      n_total++;
      if ({core_qready, mdu_pready} !== {4'b0000, 1'b1}) $display("FAIL limit_same_cycle got=%0h exp=1", {core_qready, mdu_pready}); else n_pass++;
      tick();
      mdu_pvalid = 1'b0;
      #1;
      n_total++;
      if (core_qready !== 4'b0001) $display("FAIL limit_release got=%0h exp=1", core_qready); else n_pass++;
      tick();
      #1;
      n_total++;
      if (core_qready !== 4'b0000) $display("FAIL limit_refull got=%0h exp=0", core_qready); else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      mdu_qready  = 1'b0;
      core_qvalid = 4'b0010;
      core_qid[1] = 5'd9;
      core_a[1]   = 32'h11;
      core_b[1]   = 32'h22;
      core_qid[2] = 5'd4;
      core_a[2]   = 32'h33;
      #1;
      n_total++;
      if (core_qready !== 4'b0010) $display("FAIL bp_load got=%0h exp=2", core_qready); else n_pass++;
      tick();
      core_qvalid = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_total++;
         if ({core_qready, mdu_qvalid, mdu_qid, mdu_a, mdu_b} !== {4'b0000, 1'b1, 2'd1, 5'd9, 32'h11, 32'h22})
            $display("FAIL bp_hold%0d got=%0h", k, {core_qready, mdu_qvalid, mdu_qid, mdu_a, mdu_b});
         else n_pass++;
         tick();
      end
      mdu_qready = 1'b1;
      #1;
      n_total++;
      if (core_qready !== 4'b0100) $display("FAIL bp_next_winner got=%0h exp=4", core_qready); else n_pass++;
      tick();
      core_qvalid = '0;
      #1;
      n_total++;
      if ({mdu_qvalid, mdu_qid, mdu_a} !== {1'b1, 2'd2, 5'd4, 32'h33}) $display("FAIL bp_next_load got=%0h", {mdu_qvalid, mdu_qid, mdu_a}); else n_pass++;
   endtask

   task automatic test_resp_stall();
      do_reset();
      core_qvalid = 4'b1000;
      core_qid[3] = 5'd7;
      tick();
      core_qvalid = '0;
      core_pready = 4'b0111;
      mdu_pvalid  = 1'b1;
      mdu_pid     = {2'd3, 5'd7};
      mdu_pdata   = 32'h55;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_total++;
         if ({core_pvalid, mdu_pready} !== {4'b1000, 1'b0}) $display("FAIL stall_hs%0d got=%0h exp=10", k, {core_pvalid, mdu_pready}); else n_pass++;
         n_total++;
         if (dut.inflight_q !== 3'd1) $display("FAIL stall_inflight%0d got=%0d exp=1", k, dut.inflight_q); else n_pass++;
         tick();
      end
      core_pready = '1;
      #1;
      n_total++;
      if (mdu_pready !== 1'b1) $display("FAIL stall_release got=%0h exp=1", mdu_pready); else n_pass++;
      tick();
      mdu_pvalid = 1'b0;
      #1;
      n_total++;
      if (dut.inflight_q !== 3'd0) $display("FAIL stall_done got=%0d exp=0", dut.inflight_q); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      core_qvalid = 4'b0111;
      tick();
      tick();
      tick();
      core_qvalid = '0;
      mdu_qready  = 1'b0;
      #1;
      n_total++;
      if ({mdu_qvalid, dut.inflight_q} !== {1'b1, 3'd3}) $display("FAIL mid_precond got=%0h exp=b", {mdu_qvalid, dut.inflight_q}); else n_pass++;
      #1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({mdu_qvalid, mdu_qid, mdu_a, core_qready, core_pvalid} !== '0) $display("FAIL mid_outputs got=%0h exp=0", {mdu_qvalid, mdu_qid, mdu_a, core_qready, core_pvalid}); else n_pass++;
      n_total++;
      if ({stat_grants, stat_full, dut.inflight_q} !== '0) $display("FAIL mid_counters got=%0h exp=0", {stat_grants, stat_full, dut.inflight_q}); else n_pass++;
      tick();
      rst_n       = 1'b1;
      core_qvalid = 4'b1111;
      mdu_qready  = 1'b1;
      #1;
      n_total++;
      if (core_qready !== 4'b0001) $display("FAIL mid_first_grant got=%0h exp=1", core_qready); else n_pass++;
      tick();
      core_qvalid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_outstanding();
      test_backpressure();
      test_resp_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
